// File: rtl/mpu_matrix_loader_if.sv
// Byte-stream input and operand-pair output bundle for mpu_matrix_loader.
// The loader takes the slave modport; the upstream/downstream side takes the master modport.
interface mpu_matrix_loader_if #(
  parameter int unsigned DIM = 5
);
  localparam int unsigned MW = 8 * DIM * DIM;

  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          abort;
  logic [0:MW-1] matrix_a;
  logic [0:MW-1] matrix_b;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    elem_count;

  modport master (
    output in_data, in_valid, abort, out_ready,
    input  in_ready, matrix_a, matrix_b, out_valid, elem_count
  );

  modport slave (
    input  in_data, in_valid, abort, out_ready,
    output in_ready, matrix_a, matrix_b, out_valid, elem_count
  );
endinterface

// File: rtl/mpu_matrix_loader.sv
// Collects a column-major byte stream into operand matrices A then B and
// holds the complete pair for the MPU add/arith stage until it is consumed.
module mpu_matrix_loader #(
  parameter int unsigned DIM = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  mpu_matrix_loader_if.slave   bus
);
  localparam int unsigned MW    = 8 * DIM * DIM;
  localparam int unsigned IDX_W = $clog2(MW);
  localparam logic [4:0]  LAST  = 5'(DIM * DIM - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

  state_t        state_q, state_next;
  logic [4:0]    elem_q, elem_next;
  logic          out_valid_q;
  logic [0:MW-1] mat_a_q, mat_b_q;
  logic          accept_c;
  logic          wr_a, wr_b;
  logic [IDX_W-1:0] base_c;

  assign bus.in_ready   = (state_q != HOLD) && !reset;
  assign accept_c       = bus.in_valid && bus.in_ready;
  assign base_c         = IDX_W'(elem_q) << 3;
  assign bus.out_valid  = out_valid_q;
  assign bus.elem_count = elem_q;
  assign bus.matrix_a   = mat_a_q;
  assign bus.matrix_b   = mat_b_q;

  // Next-state and write-enable decode; abort overrides any accept or handshake.
  always_comb begin
    state_next = state_q;
    elem_next  = elem_q;
    wr_a       = 1'b0;
    wr_b       = 1'b0;
    if (bus.abort) begin
      state_next = LOAD_A;
      elem_next  = 5'd0;
    end else begin
      case (state_q)
        LOAD_A: if (accept_c) begin
          wr_a = 1'b1;
          if (elem_q == LAST) begin
            elem_next  = 5'd0;
            state_next = LOAD_B;
          end else begin
            elem_next = elem_q + 5'd1;
          end
        end
        LOAD_B: if (accept_c) begin
          wr_b = 1'b1;
          if (elem_q == LAST) begin
            elem_next  = 5'd0;
            state_next = HOLD;
          end else begin
            elem_next = elem_q + 5'd1;
          end
        end
        HOLD: if (bus.out_ready) state_next = LOAD_A;
        default: state_next = LOAD_A;
      endcase
    end
  end

  // Ascending-range storage puts in_data[7] at the lowest bit of each byte lane.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= LOAD_A;
      elem_q      <= 5'd0;
      out_valid_q <= 1'b0;
      mat_a_q     <= '0;
      mat_b_q     <= '0;
    end else begin
      state_q     <= state_next;
      elem_q      <= elem_next;
      out_valid_q <= (state_next == HOLD);
      if (wr_a) mat_a_q[base_c +: 8] <= bus.in_data;
      if (wr_b) mat_b_q[base_c +: 8] <= bus.in_data;
    end
  end
endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Randomized scoreboard bench for mpu_matrix_loader against a stream-level matrix model.
module tb_mpu_matrix_loader;
  localparam int unsigned DIM = 5;
  localparam int unsigned NE  = DIM * DIM;

  typedef struct packed {
    logic [0:199] a;
    logic [0:199] b;
  } pair_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  mpu_matrix_loader_if #(.DIM(DIM)) bus ();

  mpu_matrix_loader #(.DIM(DIM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // Reference model: which matrix is filling, next element, stored contents.
  int         m_phase = 0;   // 0 = filling A, 1 = filling B, 2 = pair held
  int         m_cnt   = 0;
  logic [7:0] m_a [NE];
  logic [7:0] m_b [NE];
  pair_t      exp_q [$];

  task automatic chk(input string name, input logic [399:0] act, input logic [399:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [0:199] flat(input logic [7:0] m [NE]);
    logic [0:199] v;
    for (int k = 0; k < NE; k++) v[8*k +: 8] = m[k];
    return v;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_phase = 0;
      m_cnt   = 0;
      for (int k = 0; k < NE; k++) begin
        m_a[k] = 8'h00;
        m_b[k] = 8'h00;
      end
      exp_q.delete();
    end else if (bus.abort) begin
      if (m_phase == 2) exp_q.delete();
      m_phase = 0;
      m_cnt   = 0;
    end else if (m_phase == 2) begin
      if (bus.out_ready) m_phase = 0;
    end else if (bus.in_valid) begin
      if (m_phase == 0) m_a[m_cnt] = bus.in_data;
      else              m_b[m_cnt] = bus.in_data;
      m_cnt++;
      if (m_cnt == NE) begin
        m_cnt = 0;
        m_phase++;
        if (m_phase == 2) exp_q.push_back('{a: flat(m_a), b: flat(m_b)});
      end
    end
  end

  // Monitor: per-cycle output checks plus scoreboard pop on each operand handshake.
  always @(negedge clock) begin
    if (mon_en) begin
      pair_t e;
      int bad;
      chk("in_ready", 400'(bus.in_ready), 400'((m_phase != 2) && !reset));
      chk("out_valid", 400'(bus.out_valid), 400'(m_phase == 2));
      chk("elem_count", 400'(bus.elem_count), 400'(m_cnt));
      chk("matrix_a", 400'(bus.matrix_a), 400'(flat(m_a)));
      chk("matrix_b", 400'(bus.matrix_b), 400'(flat(m_b)));
      if (m_phase == 2 && bus.out_ready && !reset) begin
        if (exp_q.size() == 0) begin
          chk("pair_queue_nonempty", 400'(0), 400'(1));
        end else begin
          e = exp_q.pop_front();
          chk("pair_a", 400'(bus.matrix_a), 400'(e.a));
          chk("pair_b", 400'(bus.matrix_b), 400'(e.b));
          bad = 0;
          for (int k = 0; k < NE; k++) begin
            int s_dut, s_ref;
            s_dut = int'($signed(bus.matrix_a[8*k +: 8])) + int'($signed(bus.matrix_b[8*k +: 8]));
            s_ref = int'($signed(e.a[8*k +: 8])) + int'($signed(e.b[8*k +: 8]));
            if (s_dut != s_ref) bad++;
          end
          chk("add_stage_sum_errors", 400'(bad), 400'(0));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one byte until a cycle with in_valid=1 occurs; a loading phase always accepts it.
  task automatic send_byte(input logic [7:0] d, input int prob, input bit noisy);
    int tries;
    logic v;
    tries = 0;
    do begin
      v = ($urandom_range(99) < prob) || (tries >= 100);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = noisy ? 1'($urandom_range(1)) : 1'b0;
      tick();
      tries++;
    end while (!v);
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'($urandom);
    bus.out_ready = 1'b0;
  endtask

  // Sit in HOLD with ignored traffic, then consume the pair.
  task automatic hold_and_release(input int n_wait);
    for (int i = 0; i < n_wait; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h7F;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("out_valid_after_handshake", 400'(bus.out_valid), 400'(0));
  endtask

  logic [7:0]   seq [2*NE];
  logic [0:199] ma, mb;

  initial begin
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Ascending signed pattern, in_valid held high.
    for (int i = 0; i < NE; i++) begin
      seq[i]      = 8'(i + 1);
      seq[NE + i] = 8'(-(i + 1));
    end
    for (int i = 0; i < 2*NE; i++) send_byte(seq[i], 100, 1'b0);
    ma = bus.matrix_a;
    mb = bus.matrix_b;
    chk("out_valid_after_50", 400'(bus.out_valid), 400'(1));
    chk("a_elem0", 400'(ma[0 +: 8]), 400'(8'h01));
    chk("a_elem24", 400'(ma[192 +: 8]), 400'(8'h19));
    chk("b_elem1", 400'(mb[8 +: 8]), 400'(8'hFE));
    hold_and_release(10);

    // Same pattern, sparse in_valid.
    for (int i = 0; i < 2*NE; i++) send_byte(seq[i], 40, 1'b0);
    chk("rand_valid_a", 400'(bus.matrix_a), 400'(ma));
    chk("rand_valid_b", 400'(bus.matrix_b), 400'(mb));
    hold_and_release(3);

    // Abort after 12 A bytes, then a uniform reload.
    for (int i = 0; i < 12; i++) send_byte(8'($urandom), 70, 1'b0);
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    tick();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_elem_count", 400'(bus.elem_count), 400'(0));
    for (int i = 0; i < 2*NE; i++) send_byte(8'h55, 80, 1'b0);
    chk("all55_a", 400'(bus.matrix_a), 400'({25{8'h55}}));
    chk("all55_b", 400'(bus.matrix_b), 400'({25{8'h55}}));
    hold_and_release(2);

    // Reset in LOAD_B at element 7.
    for (int i = 0; i < NE + 7; i++) send_byte(8'($urandom), 90, 1'b0);
    chk("pre_reset_elem_count", 400'(bus.elem_count), 400'(7));
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    chk("reset_matrix_a", 400'(bus.matrix_a), 400'(0));
    chk("reset_matrix_b", 400'(bus.matrix_b), 400'(0));
    chk("reset_elem_count", 400'(bus.elem_count), 400'(0));

    // Reset and abort together while a byte is offered.
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 90, 1'b0);
    reset        = 1'b1;
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    tick();
    reset        = 1'b0;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    chk("reset_abort_matrix_a", 400'(bus.matrix_a), 400'(0));

    // Random operand pairs with stray out_ready during loading.
    for (int r = 0; r < 5; r++) begin
      int p;
      p = int'($urandom_range(30, 100));
      for (int i = 0; i < 2*NE; i++) send_byte(8'($urandom), p, 1'b1);
      hold_and_release(int'($urandom_range(0, 5)));
    end

    // Abort while holding a pair discards it without a handshake.
    for (int i = 0; i < 2*NE; i++) send_byte(8'($urandom), 60, 1'b0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_in_hold_out_valid", 400'(bus.out_valid), 400'(0));
    tick();
    chk("scoreboard_drained", 400'(exp_q.size()), 400'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mpu_matrix_loader.md
MPU_MATRIX_LOADER -- requirements
Module: mpu_matrix_loader

Interface
REQ-001 The block SHALL have a parameter DIM, default 5, giving the matrix dimension; only DIM=5 is required to be supported and verified.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: the reset; it is synchronous and active-high.
REQ-004 The block SHALL have port in_data, input, 8 bits: signed 8-bit matrix element from the upstream byte stream.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-007 The block SHALL have port abort, input, 1 bit: discards any partial load and restarts at matrix A, element 0.
REQ-008 The block SHALL have port matrix_a, output, 8*DIM*DIM bits, ascending range [0:199]: the flattened operand A for the MPU add/arith stage.
REQ-009 The block SHALL have port matrix_b, output, 8*DIM*DIM bits, ascending range [0:199]: the flattened operand B.
REQ-010 The block SHALL have port out_valid, output, 1 bit: matrix_a and matrix_b are complete and stable.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream stage consumes the operand pair.
REQ-012 The block SHALL have port elem_count, output, 5 bits: index of the next element to be written within the current matrix.

Function
REQ-013 The FSM SHALL have exactly three states: LOAD_A, LOAD_B, HOLD.
REQ-014 An accept SHALL occur on any cycle with in_valid=1 and in_ready=1, and only then.
REQ-015 in_ready SHALL be 1 in LOAD_A and LOAD_B, 0 in HOLD, and 0 in any cycle with reset=1.
REQ-016 Accepted element k (0..24) SHALL be stored at bit offset 8*k, i.e. element (col,row) at offset 8*(row+5*col) with k=row+5*col, column-major stream order.
REQ-017 The stored byte SHALL occupy matrix_x[8k +: 8], with in_data[7] at bit 8k and in_data[0] at bit 8k+7.
REQ-018 Each accept SHALL increment elem_count by 1, with no skipped or repeated indices.
REQ-019 An accept at elem_count=24 in LOAD_A SHALL write A[24], clear elem_count to 0 and move to LOAD_B on the next cycle.
REQ-020 An accept at elem_count=24 in LOAD_B SHALL write B[24], clear elem_count to 0 and move to HOLD on the next cycle.
REQ-021 out_valid SHALL be 1 exactly while in HOLD, first asserting the cycle after the 50th accept; load-to-valid latency is 1 cycle.
REQ-022 In HOLD, out_valid=1 and out_ready=1 SHALL return the FSM to LOAD_A on the next cycle, with out_valid=0 from that cycle.
REQ-023 In HOLD, matrix_a and matrix_b SHALL remain bit-stable and in_valid SHALL be ignored.
REQ-024 After a handshake, matrix contents SHALL be retained (not cleared) and each element replaced only when rewritten by the next load.
REQ-025 No byte SHALL be accepted in the cycle of the out handshake; minimum period per operand pair is 51 cycles.
REQ-026 out_ready outside HOLD SHALL have no effect.
REQ-027 abort=1 in any state SHALL move the FSM to LOAD_A with elem_count=0 on the next cycle, drop out_valid, and leave matrix contents unchanged.
REQ-028 An accept coinciding with abort SHALL NOT write its byte.
REQ-029 All outputs except in_ready SHALL be registered; in_ready SHALL be decoded from state and reset only.

Reset
REQ-030 reset=1 at a clock edge SHALL set state=LOAD_A, elem_count=0, out_valid=0, matrix_a=0 and matrix_b=0.
REQ-031 reset SHALL take priority over abort, accepts and out handshake in the same cycle.
REQ-032 A reset asserted mid-load or in HOLD SHALL discard all progress, with no stale out_valid afterwards.

Verification
REQ-033 Stream bytes 1..25 then -1..-25 with in_valid held high, then out_ready=1 -> out_valid rises the cycle after the 50th accept; matrix_a[0+:8]=8'sd1, matrix_a[192+:8]=8'sd25, matrix_b[8+:8]=-8'sd2; out_valid falls the cycle after the handshake.
REQ-034 Repeat REQ-033 with in_valid toggling randomly -> identical final matrices; elem_count advances only on accepts.
REQ-035 Hold out_ready=0 for 10 cycles in HOLD while driving in_valid=1 with 8'h7F -> in_ready=0, matrices unchanged, out_valid stays 1.
REQ-036 Assert abort after 12 A-bytes, then stream 50 bytes of 8'h55 -> all elements read 8'h55; no accept occurs in the abort cycle.
REQ-037 Assert reset in LOAD_B at elem_count=7 -> next cycle elem_count=0, out_valid=0, matrix_a=0, matrix_b=0, state LOAD_A.
REQ-038 Drive reset and abort together with in_valid=1 -> reset behaviour only and no byte written; feed the loaded pair into the MPU add stage and compare against a software reference sum.
